arm_data_mem_sb: RTL and testbench

// - Data-memory responder for the ArmCpu data port: consumes alu_result/write_data/mem_write, returns read_data.
// - Same-cycle (combinational) read, as the single-cycle core requires.
// - Stores are posted into a FIFO store buffer, then drained one per cycle into a word RAM.
// - Backdoor port gives the bench preload/inspect access without touching the CPU side.

---
 rtl/arm_data_mem_sb.sv | 84 ++++++++
 tb/tb_arm_data_mem_sb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_data_mem_sb.sv
// arm_data_mem_sb: ArmCpu data memory with combinational load, posted-store FIFO buffer and backdoor port.
// Optional DMEM_ALIGN_CHECK_EN drops misaligned stores and flags misaligned accesses in misalign_err.
module arm_data_mem_sb #(
    parameter int ADDR_WIDTH = 10,
    parameter int SB_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [31:0]               addr,
    input  logic [31:0]               write_data,
    input  logic                      mem_write,
    output logic [31:0]               read_data,
    input  logic                      bd_we,
    input  logic [ADDR_WIDTH-1:0]     bd_addr,
    input  logic [31:0]               bd_wdata,
    output logic [31:0]               bd_rdata,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_full,
    output logic                      overflow_err,
    output logic                      misalign_err
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = SB_DEPTH[CW-1:0];

    logic [31:0]           mem     [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] sb_idx  [SB_DEPTH];
    logic [31:0]           sb_data [SB_DEPTH];
    logic [PW-1:0]         head, tail;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  aligned, drain, accept, drop;
    logic                  unused_addr;

    assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
    assign idx         = addr[ADDR_WIDTH+1:2];
    assign sb_full     = sb_count == FULL;
    assign drain       = reset_n && sb_count != '0 && !bd_we;
    // A full buffer still accepts a store when the head drains on the same edge.
    assign accept      = mem_write && aligned && (!sb_full || drain);
    assign drop        = mem_write && aligned && sb_full && !drain;
    assign bd_rdata    = mem[bd_addr];

`ifdef DMEM_ALIGN_CHECK_EN
    assign aligned = addr[1:0] == 2'b00;
    always_ff @(posedge clk) begin
        if (!reset_n) misalign_err <= 1'b0;
        else if (!aligned) misalign_err <= 1'b1;
    end
`else
    assign aligned      = 1'b1;
    assign misalign_err = 1'b0;
`endif

    // Later (younger) matching entries override older ones and the RAM.
    always_comb begin
        read_data = mem[idx];
        for (int i = 0; i < SB_DEPTH; i++) begin
            read_data = (CW'(i) < sb_count && sb_idx[head + PW'(i)] == idx) ? sb_data[head + PW'(i)] : read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head         <= '0;
            tail         <= '0;
            sb_count     <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (accept) begin
                sb_idx[tail]  <= idx;
                sb_data[tail] <= write_data;
                tail          <= tail + 1'b1;
            end
            if (drain) head <= head + 1'b1;
            sb_count <= sb_count + CW'(accept) - CW'(drain);
            if (drop) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_wdata;
        else if (drain) mem[sb_idx[head]] <= sb_data[head];
    end
endmodule

// File: tb/tb_arm_data_mem_sb.sv
// tb_arm_data_mem_sb: queue-based store-buffer model checked every cycle, plus directed literal checks.
module tb_arm_data_mem_sb;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr, write_data, read_data, bd_wdata, bd_rdata;
    logic        mem_write, bd_we, sb_full, overflow_err, misalign_err;
    logic [9:0]  bd_addr;
    logic [2:0]  sb_count;
    int          vectors = 0, miscompares = 0;
    bit          chk_on = 1'b0;

    typedef struct {logic [9:0] idx; logic [31:0] d;} ent_t;
    ent_t        q[$];
    logic [31:0] m_ram [1024];
    logic        m_ovf = 1'b0, m_mis = 1'b0;

    arm_data_mem_sb #(.ADDR_WIDTH(10), .SB_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .write_data(write_data), .mem_write(mem_write),
        .read_data(read_data), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
        .sb_count(sb_count), .sb_full(sb_full), .overflow_err(overflow_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'(i) * 32'h9E3779B1;
    endfunction

    function automatic logic [31:0] mread(input logic [9:0] i);
        for (int k = q.size() - 1; k >= 0; k--) if (q[k].idx == i) return q[k].d;
        return m_ram[i];
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Model: backdoor write, drain of oldest entry, then enqueue or drop.
    always @(posedge clk) begin
        bit drn, full, ok;
        if (bd_we) m_ram[bd_addr] = bd_wdata;
        if (!reset_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_mis = 1'b0;
        end else begin
            ok = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
            ok = addr[1:0] == 2'b00;
            if (!ok) m_mis = 1'b1;
`endif
            full = q.size() == 4;
            drn  = q.size() > 0 && !bd_we;
            if (drn) begin
                m_ram[q[0].idx] = q[0].d;
                void'(q.pop_front());
            end
            if (mem_write && ok) begin
                if (full && !drn) m_ovf = 1'b1;
                else q.push_back('{addr[11:2], write_data});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model read_data", read_data, mread(addr[11:2]));
            chk("model bd_rdata", bd_rdata, m_ram[bd_addr]);
            chk("model sb_count", 32'(sb_count), 32'(q.size()));
            chk("model sb_full", 32'(sb_full), 32'(q.size() == 4));
            chk("model overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("model misalign_err", 32'(misalign_err), 32'(m_mis));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr = a; write_data = d; mem_write = 1'b1;
        step();
        mem_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; addr = '0; write_data = '0; mem_write = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        step(); step();
        reset_n = 1'b1;
        bd_we = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            bd_addr = 10'(i); bd_wdata = pat(i);
            step();
        end
        bd_we = 1'b0;
        chk_on = 1'b1;
        step();

        // 1: backdoor preload then CPU load
        bd_we = 1'b1; bd_addr = 10'h3F; bd_wdata = 32'hFF;
        step();
        bd_we = 1'b0; addr = 32'hFC;
        #1;
        chk("t1 read_data", read_data, 32'h000000FF);
        chk("t1 sb_count", 32'(sb_count), 0);

        // 2: store is visible immediately, drains next edge
`ifdef DMEM_ALIGN_CHECK_EN
        store(32'hFC, 32'd7);
`else
        store(32'hFF, 32'd7);
`endif
        #1;
        chk("t2 read_data", read_data, 32'd7);
        chk("t2 sb_count", 32'(sb_count), 1);
        step();
        bd_addr = 10'h3F;
        #1;
        chk("t2 drained count", 32'(sb_count), 0);
        chk("t2 bd_rdata", bd_rdata, 32'd7);

        // 3: fill with drain blocked, overflow, then drain out
        bd_we = 1'b1; bd_addr = 10'h200; bd_wdata = 32'hDEAD0000;
        for (int k = 1; k <= 4; k++) store(32'(k) << 2, 32'h100 + 32'(k));
        #1;
        chk("t3 sb_full", 32'(sb_full), 1);
        chk("t3 sb_count full", 32'(sb_count), 4);
        store(32'h18, 32'h999);
        #1;
        chk("t3 overflow_err", 32'(overflow_err), 1);
        chk("t3 sb_count held", 32'(sb_count), 4);
        bd_we = 1'b0;
        for (int e = 3; e >= 0; e--) begin
            step();
            chk("t3 drain count", 32'(sb_count), 32'(e));
        end
        for (int k = 1; k <= 4; k++) begin
            bd_addr = 10'(k);
            #1;
            chk("t3 ram word", bd_rdata, 32'h100 + 32'(k));
        end

        // 4: youngest of two pending stores to one word wins
        bd_we = 1'b1; bd_addr = 10'h300; bd_wdata = 32'h1234;
        store(32'h14, 32'hA);
        store(32'h14, 32'hB);
        addr = 32'h14;
        #1;
        chk("t4 read_data youngest", read_data, 32'hB);
        chk("t4 sb_count", 32'(sb_count), 2);
        bd_we = 1'b0;
        step(); step();
        bd_addr = 10'd5;
        #1;
        chk("t4 sb_count drained", 32'(sb_count), 0);
        chk("t4 ram word5", bd_rdata, 32'hB);

        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        chk("reset clears overflow", 32'(overflow_err), 0);

        // 5: full buffer that drains still accepts a store
        bd_we = 1'b1;
        for (int k = 10; k <= 13; k++) store(32'(k) << 2, 32'h200 + 32'(k));
        bd_we = 1'b0;
        store(32'h24, 32'h55);
        #1;
        chk("t5 sb_count", 32'(sb_count), 4);
        chk("t5 overflow_err", 32'(overflow_err), 0);
        chk("t5 read_data", read_data, 32'h55);

        // 6: reset with three pending discards them
        step();
        #1;
        chk("t6 sb_count pre", 32'(sb_count), 3);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bd_addr = 10'd12; addr = 32'h24;
        #1;
        chk("t6 sb_count", 32'(sb_count), 0);
        chk("t6 sb_full", 32'(sb_full), 0);
        chk("t6 overflow_err", 32'(overflow_err), 0);
        chk("t6 misalign_err", 32'(misalign_err), 0);
        chk("t6 word12 unchanged", bd_rdata, pat(12));
        chk("t6 word9 unchanged", read_data, pat(9));
        bd_addr = 10'd11;
        #1;
        chk("t6 word11 drained", bd_rdata, 32'h20B);

        // aliasing: high address bits ignored
        store(32'hFFFF_F000 | 32'h0C, 32'hCAFE);
        addr = 32'h0C;
        #1;
        chk("alias read_data", read_data, 32'hCAFE);
        step();

`ifdef DMEM_ALIGN_CHECK_EN
        store(32'h102, 32'h1);
        addr = 32'h0;
        #1;
        chk("misalign_err set", 32'(misalign_err), 1);
        chk("misalign store dropped", 32'(sb_count), 0);
`endif
        step(); step();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
